keypad_row_decoder: RTL

//   Reads the row lines of the 4x4 keypad while the scan counter sweeps columns.

---
 rtl/keypad_row_decoder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_row_decoder.sv
// keypad_row_decoder: column-scanned 4x4 keypad reader. Holds each column for
// DWELL_CYCLES, freezes the scan on a press, debounces press and release on the
// captured row, and reports one hex code per accepted press.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_row_decoder #(
  parameter int DWELL_CYCLES    = 4000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_CYCLES   = 480000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] rows_n_i,
  input  logic [1:0] encoded_cols_i,
  output logic       scan_counter_en_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_held_o
);

  // state    | meaning
  // SCAN     | sweeping columns, sampling rows at end of each dwell
  // DEBOUNCE | column frozen, waiting for captured row to stay low
  // HELD     | key accepted, waiting for captured row to go high
  // RELEASE  | captured row high, waiting for it to stay high
  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_e;

  localparam int MAX_A = (DWELL_CYCLES > DEBOUNCE_CYCLES) ? DWELL_CYCLES : DEBOUNCE_CYCLES;
  localparam int MAX_P = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] DWELL_TC = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] DEB_TC   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_e        state_q, state_d;
  logic [3:0]    sync1_q, sync2_q;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] deb_q, deb_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic          scan_en_q, scan_en_d;
  logic          cap_low;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_TC = CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0] rep_q, rep_d;
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + ONE;
  endfunction

  // Lowest-index active (low) row wins when several rows are pressed together.
  function automatic logic [1:0] lowest_row(input logic [3:0] rn);
    if (!rn[0])      return 2'd0;
    else if (!rn[1]) return 2'd1;
    else if (!rn[2]) return 2'd2;
    else             return 2'd3;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
      4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
      4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
      4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
    endcase
  endfunction

  assign cap_low = ~sync2_q[row_q];

  // Synchronizer, state register, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      state_q     <= ST_SCAN;
      dwell_q     <= '0;
      deb_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      scan_en_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      sync1_q     <= rows_n_i;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      row_q       <= row_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      scan_en_q   <= scan_en_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  // Next-state logic: scan, freeze on press, debounce press and release.
  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    row_d       = row_q;
    col_d       = col_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    scan_en_d   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d       = '0;
`endif
    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_TC) begin
          dwell_d = '0;
          if (sync2_q != 4'hF) begin
            row_d   = lowest_row(sync2_q);
            col_d   = encoded_cols_i;
            deb_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            scan_en_d = 1'b1;
          end
        end else begin
          dwell_d = sat_inc(dwell_q);
        end
      end
      ST_DEBOUNCE: begin
        if (!cap_low) begin
          state_d = ST_SCAN;
          dwell_d = '0;
        end else if (deb_q == DEB_TC) begin
          key_code_d  = key_map(row_q, col_q);
          key_valid_d = 1'b1;
          state_d     = ST_HELD;
        end else begin
          deb_d = sat_inc(deb_q);
        end
      end
      ST_HELD: begin
        if (!cap_low) begin
          state_d = ST_RELEASE;
          deb_d   = '0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (rep_q == REP_TC) begin
          key_valid_d = 1'b1;
          rep_d       = '0;
        end else begin
          rep_d = sat_inc(rep_q);
        end
`endif
      end
      default: begin
        if (cap_low) begin
          state_d = ST_HELD;
        end else if (deb_q == DEB_TC) begin
          state_d   = ST_SCAN;
          dwell_d   = '0;
          scan_en_d = 1'b1;
        end else begin
          deb_d = sat_inc(deb_q);
        end
      end
    endcase
    key_held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);
  end

  assign scan_counter_en_o = scan_en_q;
  assign key_code_o        = key_code_q;
  assign key_valid_o       = key_valid_q;
  assign key_held_o        = key_held_q;

endmodule
